plab2_proc_muldiv_unit: RTL and testbench
=========================================

Name: plab2_proc_muldiv_unit

Overview:
- Iterative integer multiply/divide unit in the X stage of the 5-stage pipelined processor, in parallel with the main ALU.
- Takes operands from the same bypass muxes that feed the ALU. Its result joins the X-stage result mux.
- Uses val/rdy handshakes on request and response so the control unit can stall D/X while an operation is in flight.
- Carries the same domain security label as the other datapath components.

Parameters:
- p_nbits, 32, operand/result width. Must be even and >= 4; the counter is $clog2(p_nbits)+1 bits.

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- domain  input  1  security domain of current instruction; label {L}
- req_val  input  1  request valid
- req_rdy  output  1  unit can accept a request
- req_fn  input  3  0=MUL (low word), 1=DIV, 2=DIVU, 3=REM, 4=REMU; 5-7 illegal; label {Ctrl domain}
- req_a  input  p_nbits  operand A (multiplicand/dividend); label {Data domain}
- req_b  input  p_nbits  operand B (multiplier/divisor); label {Data domain}
- resp_val  output  1  result valid
- resp_rdy  input  1  consumer accepts result
- resp_result  output  p_nbits  result; label {Data domain}
- busy  output  1  high in CALC or DONE; used by control for stall

Behaviour:
- States:
  - IDLE: req_rdy=1.
  - CALC: iterating.
  - DONE: resp_val=1.
- Reset: state=IDLE, counter=0, accumulators=0, resp_result=0, resp_val=0, busy=0, req_rdy=1. A reset in any state abandons the operation; no response is ever produced for it.
- IDLE -> CALC on posedge with req_val && req_rdy. On that edge, latch fn, domain and operand magnitudes, set counter=p_nbits.
- Signed ops (DIV, REM) latch magnitudes and record sign flags:
  - quotient sign = a[msb]^b[msb]
  - remainder sign = a[msb]
- MUL is sign-agnostic: the low word is identical, so operands are latched raw.
- CALC runs one iteration per cycle and decrements the counter:
  - MUL: shift-add. If b[0], add a into product; shift a left 1, b right 1.
  - DIV/REM: restoring divide. Shift {rem,quo} left 1, trial-subtract divisor from rem. If non-negative, keep the difference and set quo[0]=1.
- CALC -> DONE when the counter reaches 1 and that iteration completes. Exactly p_nbits cycles in CALC.
- Latency: accept at edge N gives resp_val=1 from cycle N+p_nbits+1 (33 for the default).
- DONE: resp_result holds the sign-corrected final value and is stable while resp_val && !resp_rdy. DONE -> IDLE on resp_val && resp_rdy.
- req_rdy=0 in CALC and DONE. There is no same-cycle accept in DONE; the next request is accepted earliest one cycle after the response handshake.
- Arithmetic is mod 2^p_nbits; MUL returns the low p_nbits of the product.
- Divide by zero: quotient = all ones (0xFFFFFFFF), remainder = dividend. This holds for signed and unsigned. It still takes full latency.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0. This must fall out of the magnitude path.
- Illegal fn: treated as MUL; a simulation-only $display warning is issued.
- Inputs are ignored while not in IDLE.

Optional Feature:
- Macro: PLAB2_PROC_MULDIV_EARLY_EXIT_EN.
- When defined, MUL goes CALC -> DONE on the first cycle after the latched multiplier has shifted to zero. MUL latency becomes (index of highest set bit of b)+2 cycles; b=0 gives 1 CALC cycle. DIV/REM are unaffected.
- When undefined, all ops take fixed p_nbits cycles. This is the default because timing is operand-independent, which is required for the domain-isolated configuration. Early exit leaks {Data domain} timing into {Ctrl domain} stall.

Test Plan:
- MUL 7 x 6, resp_rdy=1 -> resp_val exactly 33 cycles after accept, result 42; req_rdy low for the whole operation.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1); DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
- resp_rdy held low 10 cycles in DONE -> resp_val and resp_result (0x00000015 from MUL 3x7) stable; req_val asserted meanwhile is not accepted.
- reset pulsed at CALC cycle 15 of a DIV -> next cycle IDLE, req_rdy=1, resp_val=0; a new MUL 2x2 returns 4 with normal latency.
- With PLAB2_PROC_MULDIV_EARLY_EXIT_EN: MUL 0x12345678 x 3 -> 0x369D0368 after 3 cycles; MUL x 0 -> 0 after 2 cycles; without the macro both take 33 cycles.

Source files
------------

// File: rtl/plab2_proc_muldiv_unit.sv
// plab2_proc_muldiv_unit
//   Iterative integer multiply / divide unit for the X stage. It sits next to
//   the ALU, takes the same bypassed operands and returns its result through
//   val/rdy handshakes so control can stall D/X while an operation runs.
//
//   MUL  : shift-add, low p_nbits of the product.
//   DIV/DIVU/REM/REMU : restoring divide on magnitudes, with the sign fixed up
//   at the end for the signed ops.
//
// Ports
//   clk, reset     clock, synchronous active-high reset
//   domain         security domain of the current instruction (latched on accept)
//   req_val/rdy    request handshake; req_fn selects the op, req_a/req_b operands
//   resp_val/rdy   response handshake; resp_result holds the result in DONE
//   busy           high while CALC or DONE
//
// Parameter
//   p_nbits        operand/result width (even, >= 4)
//
// Optional feature macro
//   PLAB2_PROC_MULDIV_EARLY_EXIT_EN : MUL finishes as soon as the remaining
//   multiplier bits are zero. Left undefined, every op takes exactly p_nbits
//   CALC cycles so timing never depends on operand data.

module plab2_proc_muldiv_unit #(
  parameter int p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               domain,
  input  logic               req_val,
  output logic               req_rdy,
  input  logic [2:0]         req_fn,
  input  logic [p_nbits-1:0] req_a,
  input  logic [p_nbits-1:0] req_b,
  output logic               resp_val,
  input  logic               resp_rdy,
  output logic [p_nbits-1:0] resp_result,
  output logic               busy
);

  localparam int c_cntw = $clog2(p_nbits) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [c_cntw-1:0]  r_cnt;
  logic [p_nbits-1:0] r_a;       // MUL: shifted multiplicand; DIV: dividend shifting into quotient
  logic [p_nbits-1:0] r_b;       // MUL: shifted multiplier;   DIV: divisor magnitude
  logic [p_nbits-1:0] r_acc;     // MUL: product;              DIV: partial remainder
  logic               r_is_mul;
  logic               r_is_rem;
  logic               r_neg_quo;
  logic               r_neg_rem;
  logic               r_domain;

  // ---------------------------------------------------------------------------
  // Request decode (only meaningful in IDLE)
  // ---------------------------------------------------------------------------
  logic               w_accept;
  logic               w_fn_illegal;
  logic               w_is_mul;
  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [p_nbits-1:0] w_a_mag;
  logic [p_nbits-1:0] w_b_mag;

  assign w_accept     = req_val && req_rdy;
  assign w_fn_illegal = (req_fn > 3'd4);
  // Illegal encodings fall back to MUL.
  assign w_is_mul     = (req_fn == 3'd0) || w_fn_illegal;
  assign w_signed     = (req_fn == 3'd1) || (req_fn == 3'd3);
  assign w_a_neg      = w_signed && req_a[p_nbits-1];
  assign w_b_neg      = w_signed && req_b[p_nbits-1];
  // -0x80..0 wraps to itself, which is exactly the unsigned magnitude we want.
  assign w_a_mag      = w_a_neg ? -req_a : req_a;
  assign w_b_mag      = w_b_neg ? -req_b : req_b;

  // ---------------------------------------------------------------------------
  // One iteration of each algorithm
  // ---------------------------------------------------------------------------
  logic [p_nbits:0]   w_rem_sh;   // one extra bit: shifted remainder can reach 2*divisor
  logic [p_nbits:0]   w_diff;
  logic               w_ge;
  logic [p_nbits-1:0] w_sum;

  assign w_rem_sh = {r_acc, r_a[p_nbits-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_b});
  assign w_diff   = w_rem_sh - {1'b0, r_b};
  assign w_sum    = r_acc + r_a;

  logic w_mul_exit;
`ifdef PLAB2_PROC_MULDIV_EARLY_EXIT_EN
  // After this iteration the multiplier would be zero, so nothing more to add.
  assign w_mul_exit = r_is_mul && (r_b[p_nbits-1:1] == '0);
`else
  assign w_mul_exit = 1'b0;
`endif

  logic w_last;
  assign w_last = (r_cnt == c_cntw'(1)) || w_mul_exit;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (req_val)  w_state_next = S_CALC;
      S_CALC:  if (w_last)   w_state_next = S_DONE;
      S_DONE:  if (resp_rdy) w_state_next = S_IDLE;
      default:               w_state_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  logic [p_nbits-1:0] w_final;

  always_comb begin
    if (r_is_mul)
      w_final = r_acc;
    else if (r_is_rem)
      w_final = r_neg_rem ? -r_acc : r_acc;
    else if (r_neg_quo && (r_b != '0))
      w_final = -r_a;
    else
      // Divide by zero leaves an all-ones quotient that must not be negated.
      w_final = r_a;
  end

  always_comb begin
    req_rdy     = (r_state == S_IDLE);
    resp_val    = (r_state == S_DONE);
    busy        = (r_state != S_IDLE);
    resp_result = (r_state == S_DONE) ? w_final : '0;
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_is_mul  <= 1'b0;
      r_is_rem  <= 1'b0;
      r_neg_quo <= 1'b0;
      r_neg_rem <= 1'b0;
      r_domain  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt     <= c_cntw'(p_nbits);
            r_acc     <= '0;
            r_is_mul  <= w_is_mul;
            r_is_rem  <= (req_fn == 3'd3) || (req_fn == 3'd4);
            r_neg_quo <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_domain  <= domain;
            // The low product word is sign-agnostic, so MUL keeps raw operands.
            r_a       <= w_is_mul ? req_a : w_a_mag;
            r_b       <= w_is_mul ? req_b : w_b_mag;
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt - c_cntw'(1);
          if (r_is_mul) begin
            if (r_b[0]) r_acc <= w_sum;
            r_a <= {r_a[p_nbits-2:0], 1'b0};
            r_b <= {1'b0, r_b[p_nbits-1:1]};
          end else begin
            // When the trial subtract fails the shifted remainder is below the
            // divisor, so its top bit is zero and truncation is safe.
            r_acc <= w_ge ? w_diff[p_nbits-1:0] : w_rem_sh[p_nbits-1:0];
            r_a   <= {r_a[p_nbits-2:0], w_ge};
          end
        end
        default: ;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && w_accept && w_fn_illegal)
      $warning("plab2_proc_muldiv_unit: illegal fn %0d, executing as MUL", req_fn);
  end
`endif

  // The latched domain is the security label of the op in flight; it has no
  // functional consumer inside this unit.
  logic w_unused;
  assign w_unused = &{1'b0, r_domain, w_diff[p_nbits]};

endmodule

// File: tb/tb_plab2_proc_muldiv_unit.sv
module tb_plab2_proc_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        domain;
  logic        req_val;
  logic        req_rdy;
  logic [2:0]  req_fn;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_val;
  logic        resp_rdy;
  logic [31:0] resp_result;
  logic        busy;

  plab2_proc_muldiv_unit #(.p_nbits(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .domain      (domain),
    .req_val     (req_val),
    .req_rdy     (req_rdy),
    .req_fn      (req_fn),
    .req_a       (req_a),
    .req_b       (req_b),
    .resp_val    (resp_val),
    .resp_rdy    (resp_rdy),
    .resp_result (resp_result),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] exp;
    int          lat;
    int          acc;
    string       name;
  } txn_t;

  txn_t sb[$];

  // Latency in cycles, counting the cycle the request is presented as cycle 0.
  function automatic int lat_mul(input logic [31:0] b);
    int h;
    h = -1;
`ifdef PLAB2_PROC_MULDIV_EARLY_EXIT_EN
    for (int i = 0; i < 32; i++) if (b[i]) h = i;
    if (h < 0) return 2;
    return h + 2;
`else
    return 33 + (h - h);
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: compares whatever the DUT presents against the scoreboard head
  // ---------------------------------------------------------------------------
  int first_v = -1;
  bit ctl_bad = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      first_v = -1;
      ctl_bad = 1'b0;
    end else if (sb.size() == 0) begin
      if (resp_val) check("spurious_resp_val", {31'b0, resp_val}, 32'd0);
    end else if (cyc >= sb[0].acc) begin
      if (req_rdy !== 1'b0 || busy !== 1'b1) ctl_bad = 1'b1;
      if (resp_val) begin
        if (first_v < 0) first_v = cyc;
        if (!resp_rdy) begin
          check({sb[0].name, "_hold"}, resp_result, sb[0].exp);
        end else begin
          check({sb[0].name, "_result"}, resp_result, sb[0].exp);
          check({sb[0].name, "_latency"}, first_v - sb[0].acc + 1, sb[0].lat);
          check({sb[0].name, "_rdy_busy"}, {31'b0, ctl_bad}, 32'd0);
          $display("txn %s result=%h latency=%0d", sb[0].name, resp_result,
                   first_v - sb[0].acc + 1);
          void'(sb.pop_front());
          first_v = -1;
          ctl_bad = 1'b0;
        end
      end else if (first_v >= 0) begin
        check({sb[0].name, "_val_dropped"}, {31'b0, resp_val}, 32'd1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic issue(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input string name);
    int t;
    txn_t x;
    t = 0;
    @(negedge clk);
    req_val = 1'b1;
    req_fn  = fn;
    req_a   = a;
    req_b   = b;
    domain  = ~domain;
    while (!req_rdy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!req_rdy) check({name, "_issue_timeout"}, {31'b0, req_rdy}, 32'd1);
    x.exp  = exp;
    x.lat  = lat;
    x.acc  = cyc + 1;
    x.name = name;
    sb.push_back(x);
    @(posedge clk);
    #1;
    req_val = 1'b0;
    req_a   = $urandom;
    req_b   = $urandom;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic run(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int lat, input string name);
    issue(fn, a, b, exp, lat, name);
    drain();
  endtask

  initial begin
    int t;
    reset    = 1'b1;
    domain   = 1'b0;
    req_val  = 1'b0;
    req_fn   = 3'd0;
    req_a    = 32'd0;
    req_b    = 32'd0;
    resp_rdy = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_req_rdy",  {31'b0, req_rdy},  32'd1);
    check("reset_resp_val", {31'b0, resp_val}, 32'd0);
    check("reset_busy",     {31'b0, busy},     32'd0);
    check("reset_result",   resp_result,       32'd0);
    reset = 1'b0;

    // Main function: directed vectors, expected values computed by hand.
    run(3'd0, 32'd7,        32'd6,        32'd42,       lat_mul(32'd6), "mul_7x6");
    run(3'd1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, "div_m7_2");
    run(3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, "rem_m7_2");
    run(3'd2, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 33, "divu_big_2");
    run(3'd4, 32'hFFFFFFF9, 32'd2,        32'd1,        33, "remu_big_2");
    run(3'd1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33, "div_ovf");
    run(3'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0,        33, "rem_ovf");
    run(3'd2, 32'd5,        32'd0,        32'hFFFFFFFF, 33, "divu_by0");
    run(3'd4, 32'd5,        32'd0,        32'd5,        33, "remu_by0");
    run(3'd1, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 33, "div_m5_by0");
    run(3'd3, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 33, "rem_m5_by0");
    run(3'd1, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 33, "div_100_m7");
    run(3'd3, 32'd100,      32'hFFFFFFF9, 32'd2,        33, "rem_100_m7");
    run(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        lat_mul(32'hFFFFFFFF), "mul_m1_m1");
    run(3'd0, 32'h12345678, 32'd3,        32'h369D0368, lat_mul(32'd3), "mul_1234_x3");
    run(3'd0, 32'h12345678, 32'd0,        32'd0,        lat_mul(32'd0), "mul_x0");
    run(3'd5, 32'd3,        32'd5,        32'd15,       lat_mul(32'd5), "illegal_as_mul");

    // Consumer stalls in DONE: result must hold, new requests must be ignored.
    resp_rdy = 1'b0;
    issue(3'd0, 32'd3, 32'd7, 32'h00000015, lat_mul(32'd7), "mul_stall");
    t = 0;
    while (!resp_val && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("stall_resp_val_seen", {31'b0, resp_val}, 32'd1);
    repeat (10) begin
      @(negedge clk);
      req_val = 1'b1;
      req_fn  = 3'd2;
      req_a   = 32'd99;
      req_b   = 32'd4;
    end
    @(posedge clk);
    #1;
    req_val  = 1'b0;
    resp_rdy = 1'b1;
    drain();
    repeat (3) @(negedge clk);
    check("post_stall_req_rdy", {31'b0, req_rdy}, 32'd1);
    check("post_stall_busy",    {31'b0, busy},    32'd0);

    // Reset in the middle of a divide abandons it without a response.
    issue(3'd1, 32'd1000, 32'd7, 32'd142, 33, "div_aborted");
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    reset = 1'b0;
    @(negedge clk);
    check("abort_req_rdy",  {31'b0, req_rdy},  32'd1);
    check("abort_resp_val", {31'b0, resp_val}, 32'd0);
    check("abort_busy",     {31'b0, busy},     32'd0);
    run(3'd0, 32'd2, 32'd2, 32'd4, lat_mul(32'd2), "mul_after_abort");

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
